// File: rtl/counter_tdc.sv
// Counter-based TDC: measures rising-edge distance between ref_in and fb_in in clk
// cycles, reporting a saturated magnitude plus which edge came first.

module counter_tdc_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync_pipe;
  logic              hist;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sync_pipe <= '0;
      hist      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[STAGES-2:0], din};
      hist      <= sync_pipe[STAGES-1];
    end
  end

  assign rise = sync_pipe[STAGES-1] & ~hist;
endmodule

module counter_tdc #(
  parameter int inout_width = 8,
  parameter int sync_stages = 2,
  parameter int timeout     = 1023
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ref_in,
  input  logic                   fb_in,
  output logic [inout_width-1:0] tdc_code,
  output logic                   lead,
  output logic                   code_valid
);
  localparam int CW = $clog2(timeout + 1);
  localparam logic [inout_width-1:0] MAXC = '1;

  typedef enum logic [1:0] {IDLE, REF_FIRST, FB_FIRST} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   emit, lead_nx;
  logic [inout_width-1:0] code_nx, cnt_sat;
  logic [1:0]             pins, rise;
  logic                   ref_rise, fb_rise;

  // lane 0 = ref, lane 1 = fb
  assign pins = {fb_in, ref_in};

  for (genvar i = 0; i < 2; i++) begin : g_edge
    counter_tdc_edge #(.STAGES(sync_stages)) u_edge (
      .clk  (clk),
      .rstn (rstn),
      .din  (pins[i]),
      .rise (rise[i])
    );
  end

  assign ref_rise = rise[0];
  assign fb_rise  = rise[1];

  always_comb begin
    logic [31:0] cnt32;
    cnt32   = 32'(cnt);
    cnt_sat = (cnt32 > 32'(MAXC)) ? MAXC : cnt32[inout_width-1:0];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    emit     = 1'b0;
    code_nx  = '0;
    lead_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          emit = 1'b1;
        end else if (ref_rise) begin
          cnt_nx   = CW'(1);
          state_nx = REF_FIRST;
        end else if (fb_rise) begin
          cnt_nx   = CW'(1);
          state_nx = FB_FIRST;
        end
      end
      REF_FIRST: begin
        if (fb_rise) begin
          emit    = 1'b1;
          code_nx = cnt_sat;
          if (ref_rise) begin
            cnt_nx = CW'(1);
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end else if (ref_rise) begin
          // second ref edge with no fb in between: report a slip, restart on it
          emit    = 1'b1;
          code_nx = MAXC;
          cnt_nx  = CW'(1);
        end else if (cnt == CW'(timeout)) begin
          emit     = 1'b1;
          code_nx  = MAXC;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      FB_FIRST: begin
        lead_nx = 1'b1;
        if (ref_rise) begin
          emit    = 1'b1;
          code_nx = cnt_sat;
          if (fb_rise) begin
            cnt_nx = CW'(1);
          end else begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end else if (fb_rise) begin
          emit    = 1'b1;
          code_nx = MAXC;
          cnt_nx  = CW'(1);
        end else if (cnt == CW'(timeout)) begin
          emit     = 1'b1;
          code_nx  = MAXC;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      tdc_code   <= '0;
      lead       <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      code_valid <= emit;
      if (emit) begin
        tdc_code <= code_nx;
        lead     <= lead_nx;
      end
    end
  end
endmodule

// File: tb/tb_counter_tdc.sv
// Directed bench for counter_tdc: every strobe is logged and compared against
// hand-computed codes, lead flags and latencies.

module tb_counter_tdc;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic [7:0] tdc_code;
  logic       lead;
  logic       code_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_code[$];
  logic       q_lead[$];
  int         q_cyc[$];

  counter_tdc #(.inout_width(8), .sync_stages(2), .timeout(1023)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .tdc_code   (tdc_code),
    .lead       (lead),
    .code_valid (code_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      q_code.push_back(tdc_code);
      q_lead.push_back(lead);
      q_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    q_code.delete();
    q_lead.delete();
    q_cyc.delete();
  endtask

  // first edge, d cycles later the second edge, then let the strobe land and idle
  task automatic pair(input bit ref_first, input int d);
    if (ref_first) ref_in = 1'b1; else fb_in = 1'b1;
    step(d);
    if (ref_first) fb_in = 1'b1; else ref_in = 1'b1;
    step(8);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    int c1, lat;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ref_in = i[0];
      fb_in  = i[1];
      step(1);
      checks++;
      if ({code_valid, lead, tdc_code} !== 10'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b lead=%b code=%0d expected 0 0 0", code_valid, lead, tdc_code);
      end
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(2);
    rstn = 1'b0;
    step(4);
    clear_log();
    ref_in = 1'b1;
    step(5);
    c1 = cyc;
    fb_in = 1'b1;
    step(8);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
    checks++;
    if (q_code.size() !== 1) begin
      errors++;
      $display("FAIL first_strobe_count: got %0d expected 1", q_code.size());
    end
    if (q_code.size() >= 1) begin
      checks++;
      if (q_code[0] !== 8'd5 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL first_measure: got code=%0d lead=%b expected code=5 lead=0", q_code[0], q_lead[0]);
      end
      lat = q_cyc[0] - c1;
      checks++;
      if (!(lat == 3 || lat == 4)) begin
        errors++;
        $display("FAIL first_latency: got %0d cycles expected 3..4", lat);
      end
    end
  endtask

  task automatic test_fb_lead();
    clear_log();
    pair(1'b0, 12);
    checks++;
    if (q_code.size() !== 1) begin
      errors++;
      $display("FAIL fb_lead_count: got %0d expected 1", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd12 || q_lead[0] !== 1'b1) begin
        errors++;
        $display("FAIL fb_lead: got code=%0d lead=%b expected code=12 lead=1", q_code[0], q_lead[0]);
      end
    end
    checks++;
    if (tdc_code !== 8'd12 || lead !== 1'b1 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL fb_lead_hold: got code=%0d lead=%b valid=%b expected 12 1 0", tdc_code, lead, code_valid);
    end
  endtask

  task automatic test_simultaneous();
    clear_log();
    ref_in = 1'b1;
    fb_in  = 1'b1;
    step(8);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
    pair(1'b1, 3);
    checks++;
    if (q_code.size() !== 2) begin
      errors++;
      $display("FAIL simul_count: got %0d expected 2", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd0 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL simul_code: got code=%0d lead=%b expected code=0 lead=0", q_code[0], q_lead[0]);
      end
      checks++;
      if (q_code[1] !== 8'd3 || q_lead[1] !== 1'b0) begin
        errors++;
        $display("FAIL simul_then_idle: got code=%0d lead=%b expected code=3 lead=0", q_code[1], q_lead[1]);
      end
    end
  endtask

  task automatic test_saturation();
    int c0, dt;
    clear_log();
    pair(1'b1, 300);
    checks++;
    if (q_code.size() !== 1) begin
      errors++;
      $display("FAIL sat300_count: got %0d expected 1", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd255 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL sat300: got code=%0d lead=%b expected code=255 lead=0", q_code[0], q_lead[0]);
      end
    end
    clear_log();
    c0 = cyc;
    ref_in = 1'b1;
    step(10);
    ref_in = 1'b0;
    step(1090);
    fb_in = 1'b1;
    step(4);
    ref_in = 1'b1;
    step(8);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
    checks++;
    if (q_code.size() !== 2) begin
      errors++;
      $display("FAIL timeout_count: got %0d expected 2", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd255 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL timeout_code: got code=%0d lead=%b expected code=255 lead=0", q_code[0], q_lead[0]);
      end
      dt = q_cyc[0] - c0;
      checks++;
      if (!(dt == 1026 || dt == 1027)) begin
        errors++;
        $display("FAIL timeout_time: got %0d cycles after ref expected 1026..1027", dt);
      end
      checks++;
      if (q_code[1] !== 8'd4 || q_lead[1] !== 1'b1) begin
        errors++;
        $display("FAIL late_fb_first: got code=%0d lead=%b expected code=4 lead=1", q_code[1], q_lead[1]);
      end
    end
  endtask

  task automatic test_cycle_slip();
    clear_log();
    ref_in = 1'b1;
    step(3);
    ref_in = 1'b0;
    step(37);
    ref_in = 1'b1;
    step(7);
    fb_in = 1'b1;
    step(8);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
    checks++;
    if (q_code.size() !== 2) begin
      errors++;
      $display("FAIL slip_count: got %0d expected 2", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd255 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL slip_code: got code=%0d lead=%b expected code=255 lead=0", q_code[0], q_lead[0]);
      end
      checks++;
      if (q_code[1] !== 8'd7 || q_lead[1] !== 1'b0) begin
        errors++;
        $display("FAIL after_slip: got code=%0d lead=%b expected code=7 lead=0", q_code[1], q_lead[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    ref_in = 1'b1;
    step(52);
    rstn   = 1'b1;
    ref_in = 1'b0;
    #1;
    checks++;
    if ({code_valid, lead, tdc_code} !== 10'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b lead=%b code=%0d expected 0 0 0", code_valid, lead, tdc_code);
    end
    step(3);
    rstn = 1'b0;
    step(5);
    checks++;
    if (q_code.size() !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_strobe: got %0d strobes expected 0", q_code.size());
    end
    pair(1'b1, 9);
    checks++;
    if (q_code.size() !== 1) begin
      errors++;
      $display("FAIL post_reset_count: got %0d expected 1", q_code.size());
    end else begin
      checks++;
      if (q_code[0] !== 8'd9 || q_lead[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_code: got code=%0d lead=%b expected code=9 lead=0", q_code[0], q_lead[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fb_lead();
    test_simultaneous();
    test_saturation();
    test_cycle_slip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
